// File: rtl/cmd_pkg.sv
// Shared definitions for the flight-command link: deframer states, framing
// constants and the opcodes the command-execution FSMs agree on.
package cmd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_GET_CMD,
        ST_GET_LEN,
        ST_GET_PAY,
        ST_GET_CHK,
        ST_HOLD
    } rx_state_t;

    localparam logic [7:0] CMD_SYNC_BYTE = 8'hA5;
    localparam int         CMD_MAX_LEN   = 4;

    localparam logic [7:0] CMD_LAND    = 8'h15;
    localparam logic [7:0] CMD_TAKEOFF = 8'h16;
    localparam logic [7:0] CMD_HOVER   = 8'h17;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 8'hFF; cleared only by reset.
module sat_cnt8
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_inc) begin
            r_cnt <= sat_inc8(r_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cmd_frame_rx.sv
// Flight-command deframer: SYNC, id, len, little-endian payload, 8-bit checksum.
// Good commands are held on a valid/ready port; bad frames bump error counters.
module cmd_frame_rx
    import cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = CMD_SYNC_BYTE,
    parameter int          MAX_LEN   = CMD_MAX_LEN,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_id,
    output logic [2:0]  cmd_len,
    output logic [31:0] cmd_param,
    output logic [7:0]  chk_err_cnt,
    output logic [7:0]  len_err_cnt,
    output logic [7:0]  to_err_cnt
);

    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

    rx_state_t   r_state;
    logic        r_rx_ready;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_id;
    logic [2:0]  r_cmd_len;
    logic [31:0] r_cmd_param;
    logic [7:0]  r_sum;
    logic [1:0]  r_pay_idx;
    logic [15:0] r_idle;

    logic        w_acc;
    logic        w_in_frame;
    logic [7:0]  w_chk_sum;
    logic        w_len_bad;
    logic        w_chk_inc;
    logic        w_len_inc;
    logic        w_to_inc;

    assign w_acc      = rx_valid && r_rx_ready;
    assign w_in_frame = (r_state == ST_GET_CMD) || (r_state == ST_GET_LEN) ||
                        (r_state == ST_GET_PAY) || (r_state == ST_GET_CHK);
    assign w_chk_sum  = r_sum + rx_data;
    assign w_len_bad  = rx_data > LP_MAX_LEN;

    // Error strobes are combinational so the counters move on the edge that ends the bad cycle.
    assign w_len_inc = w_acc && (r_state == ST_GET_LEN) && w_len_bad;
    assign w_chk_inc = w_acc && (r_state == ST_GET_CHK) && (w_chk_sum != 8'd0);
    assign w_to_inc  = !w_acc && w_in_frame && (r_idle == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_rx_ready  <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_id    <= 8'd0;
            r_cmd_len   <= 3'd0;
            r_cmd_param <= 32'd0;
            r_sum       <= 8'd0;
            r_pay_idx   <= 2'd0;
            r_idle      <= 16'd0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_acc && rx_data == SYNC_BYTE) begin
                        r_state     <= ST_GET_CMD;
                        r_sum       <= 8'd0;
                        r_cmd_param <= 32'd0;
                    end
                end
                ST_GET_CMD: begin
                    if (w_acc) begin
                        r_cmd_id <= rx_data;
                        r_sum    <= w_chk_sum;
                        r_state  <= ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    if (w_acc) begin
                        if (w_len_bad) begin
                            r_state <= ST_HUNT;
                        end else begin
                            r_cmd_len <= rx_data[2:0];
                            r_sum     <= w_chk_sum;
                            r_pay_idx <= 2'd0;
                            r_state   <= (rx_data == 8'd0) ? ST_GET_CHK : ST_GET_PAY;
                        end
                    end
                end
                ST_GET_PAY: begin
                    if (w_acc) begin
                        r_cmd_param[{r_pay_idx, 3'b000} +: 8] <= rx_data;
                        r_sum <= w_chk_sum;
                        if ({1'b0, r_pay_idx} == r_cmd_len - 3'd1) begin
                            r_state <= ST_GET_CHK;
                        end else begin
                            r_pay_idx <= r_pay_idx + 2'd1;
                        end
                    end
                end
                ST_GET_CHK: begin
                    if (w_acc) begin
                        if (w_chk_sum == 8'd0) begin
                            r_state     <= ST_HOLD;
                            r_cmd_valid <= 1'b1;
                            r_rx_ready  <= 1'b0;
                        end else begin
                            r_state <= ST_HUNT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cmd_valid && cmd_ready) begin
                        r_state     <= ST_HUNT;
                        r_cmd_valid <= 1'b0;
                        r_rx_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_HUNT;
                    r_cmd_valid <= 1'b0;
                    r_rx_ready  <= 1'b1;
                end
            endcase

            // Idle timer: a byte landing on the TIMEOUT cycle beats the timeout.
            if (w_acc || !w_in_frame) begin
                r_idle <= 16'd0;
            end else if (r_idle == TIMEOUT) begin
                r_idle  <= 16'd0;
                r_state <= ST_HUNT;
            end else begin
                r_idle <= r_idle + 16'd1;
            end
        end
    end

    sat_cnt8 u_chk_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_chk_inc), .o_cnt(chk_err_cnt));
    sat_cnt8 u_len_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_len_inc), .o_cnt(len_err_cnt));
    sat_cnt8 u_to_cnt  (.clk(clk), .rst_n(rst_n), .i_inc(w_to_inc),  .o_cnt(to_err_cnt));

    assign rx_ready  = r_rx_ready;
    assign cmd_valid = r_cmd_valid;
    assign cmd_id    = r_cmd_id;
    assign cmd_len   = r_cmd_len;
    assign cmd_param = r_cmd_param;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Bench for cmd_frame_rx: frame-level reference model feeding a scoreboard,
// directed frames from the test plan followed by randomized traffic.
module tb_cmd_frame_rx;
    import cmd_pkg::*;

    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_id;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_param;
    logic [7:0]  chk_err_cnt;
    logic [7:0]  len_err_cnt;
    logic [7:0]  to_err_cnt;

    always #5 clk = ~clk;

    cmd_frame_rx dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_param(cmd_param),
        .chk_err_cnt(chk_err_cnt), .len_err_cnt(len_err_cnt), .to_err_cnt(to_err_cnt)
    );

    typedef struct {
        logic [7:0]  id;
        logic [2:0]  len;
        logic [31:0] param;
    } cmd_t;

    cmd_t       exp_q[$];
    cmd_t       last_good;
    cmd_t       mon_e;
    logic [7:0] txq[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_chk = 0;
    int         exp_len = 0;
    int         exp_to = 0;
    bit         rdy_rand = 1'b0;
    bit         rdy_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Consumer-side ready: either forced or randomly toggling.
    always @(negedge clk) begin
        cmd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Monitor: each completed command handshake is scored against the queue.
    always begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected actual id=%0h required=no command", cmd_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_id", 32'(cmd_id), 32'(mon_e.id));
                check("mon_len", 32'(cmd_len), 32'(mon_e.len));
                check("mon_param", cmd_param, mon_e.param);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_wait actual=%0b required=1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_txq(input int count, input int maxgap);
        for (int i = 0; i < count; i++) begin
            send_byte(txq[i]);
            if (maxgap > 0 && i != count - 1) idle($urandom_range(0, maxgap));
        end
    endtask

    // Builds a well-formed frame from its fields; checksum makes the byte sum wrap to zero.
    task automatic make_good(input logic [7:0] id, input int len, input logic [31:0] param);
        int   s;
        cmd_t e;
        txq.delete();
        txq.push_back(CMD_SYNC_BYTE);
        txq.push_back(id);
        txq.push_back(8'(len));
        s = int'(id) + len;
        e.param = 32'd0;
        for (int k = 0; k < len; k++) begin
            txq.push_back(param[8*k +: 8]);
            e.param[8*k +: 8] = param[8*k +: 8];
            s += int'(param[8*k +: 8]);
        end
        txq.push_back(8'((256 - (s % 256)) % 256));
        e.id  = id;
        e.len = 3'(len);
        last_good = e;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_chk_cnt"}, 32'(chk_err_cnt), 32'(exp_chk));
        check({tag, "_len_cnt"}, 32'(len_err_cnt), 32'(exp_len));
        check({tag, "_to_cnt"},  32'(to_err_cnt),  32'(exp_to));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_cmd_id"},    32'(cmd_id),    32'd0);
        check({tag, "_cmd_len"},   32'(cmd_len),   32'd0);
        check({tag, "_cmd_param"}, cmd_param,      32'd0);
        check_counters(tag);
    endtask

    task automatic garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == CMD_SYNC_BYTE) g = 8'h00;
            send_byte(g);
        end
    endtask

    initial begin
        int kind, len, p;
        logic [7:0] id;
        logic [31:0] prm;

        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Test-plan frame, full rate, ready high.
        txq = '{8'hA5, 8'h15, 8'h02, 8'h34, 8'h12, 8'hA3};
        last_good.id = 8'h15; last_good.len = 3'd2; last_good.param = 32'h0000_1234;
        exp_q.push_back(last_good);
        send_txq(6, 0);
        check("t1_valid_rise", 32'(cmd_valid), 32'd1);
        check("t1_rx_ready_hold", 32'(rx_ready), 32'd0);
        idle(1);
        check("t1_valid_one_cycle", 32'(cmd_valid), 32'd0);
        check("t1_rx_ready_back", 32'(rx_ready), 32'd1);
        check_counters("t1");

        // Garbage then zero-length frame.
        txq = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h15, 8'h00, 8'hEB};
        last_good.id = 8'h15; last_good.len = 3'd0; last_good.param = 32'd0;
        exp_q.push_back(last_good);
        send_txq(7, 0);
        idle(2);
        check_counters("t2");

        // Bad checksum, then a good frame.
        txq = '{8'hA5, 8'h15, 8'h02, 8'h34, 8'h12, 8'hA4};
        send_txq(6, 0);
        exp_chk = sat(exp_chk);
        check("t3_no_valid", 32'(cmd_valid), 32'd0);
        idle(1);
        check_counters("t3");
        make_good(CMD_TAKEOFF, 4, 32'hDEAD_BEEF);
        exp_q.push_back(last_good);
        send_txq(txq.size(), 0);
        idle(2);

        // Oversize length field, then a good frame.
        txq = '{8'hA5, 8'h15, 8'h05};
        send_txq(3, 0);
        exp_len = sat(exp_len);
        idle(1);
        check_counters("t4");
        make_good(CMD_HOVER, 3, 32'h00A5_1122);
        exp_q.push_back(last_good);
        send_txq(txq.size(), 0);
        idle(2);

        // Stall past the limit, then a gap of exactly TIMEOUT cycles which must survive.
        txq = '{8'hA5, 8'h15};
        send_txq(2, 0);
        idle(TO + 1);
        exp_to = sat(exp_to);
        check_counters("t5_stall");
        txq = '{8'hA5, 8'h15, 8'h02, 8'h34, 8'h12, 8'hA3};
        last_good.id = 8'h15; last_good.len = 3'd2; last_good.param = 32'h0000_1234;
        exp_q.push_back(last_good);
        send_txq(3, 0);
        idle(TO);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hA3);
        idle(2);
        check_counters("t5_edge");

        // Backpressure: command and rx_ready stay frozen while the consumer stalls.
        rdy_force = 1'b0;
        idle(2);
        make_good(CMD_LAND, 4, 32'h8765_4321);
        exp_q.push_back(last_good);
        send_txq(txq.size(), 0);
        rx_valid = 1'b1;
        rx_data  = CMD_SYNC_BYTE;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(cmd_valid), 32'd1);
            check("bp_rx_ready", 32'(rx_ready), 32'd0);
            check("bp_id", 32'(cmd_id), 32'(last_good.id));
            check("bp_len", 32'(cmd_len), 32'(last_good.len));
            check("bp_param", cmd_param, last_good.param);
            @(negedge clk);
        end
        rx_valid  = 1'b0;
        rdy_force = 1'b1;
        idle(3);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check_counters("bp");

        // Randomized traffic against the frame-level model.
        rdy_rand = 1'b1;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 4);
            id   = 8'($urandom_range(0, 255));
            prm  = $urandom;
            garbage($urandom_range(0, 2));
            if (kind <= 4) begin
                make_good(id, len, prm);
                exp_q.push_back(last_good);
                send_txq(txq.size(), 2);
            end else if (kind <= 6) begin
                make_good(id, len, prm);
                txq[txq.size() - 1] = txq[txq.size() - 1] + 8'(1 + $urandom_range(0, 254));
                exp_chk = sat(exp_chk);
                send_txq(txq.size(), 2);
            end else if (kind == 7) begin
                txq = '{CMD_SYNC_BYTE, id, 8'($urandom_range(5, 255))};
                exp_len = sat(exp_len);
                send_txq(3, 2);
            end else if (kind == 8) begin
                make_good(id, len, prm);
                p = $urandom_range(1, txq.size() - 1);
                send_txq(p, 2);
                idle(TO + 1);
                exp_to = sat(exp_to);
            end else begin
                make_good(CMD_SYNC_BYTE, 4, {8'hA5, prm[23:16], 8'hA5, prm[7:0]});
                exp_q.push_back(last_good);
                send_txq(txq.size(), 0);
            end
            idle(1);
            check_counters("rand");
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        idle(4);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Saturation of the checksum error counter.
        for (int i = 0; i < 256; i++) begin
            make_good(8'($urandom_range(0, 255)), $urandom_range(0, 4), $urandom);
            txq[txq.size() - 1] = txq[txq.size() - 1] ^ 8'h01;
            exp_chk = sat(exp_chk);
            send_txq(txq.size(), 0);
        end
        idle(1);
        check("sat_chk_ff", 32'(chk_err_cnt), 32'hFF);
        check_counters("sat");

        // Reset while holding a command.
        rdy_force = 1'b0;
        idle(2);
        make_good(CMD_LAND, 1, 32'h0000_0042);
        exp_q.push_back(last_good);
        send_txq(txq.size(), 0);
        idle(1);
        check("rst_hold_pre_valid", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_chk = 0; exp_len = 0; exp_to = 0;
        #1;
        check_reset_values("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        idle(2);

        // Reset mid-frame, then a good frame after release.
        make_good(CMD_TAKEOFF, 4, 32'h0102_0304);
        send_txq(5, 0);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        make_good(CMD_HOVER, 2, 32'h0000_BEEF);
        exp_q.push_back(last_good);
        send_txq(txq.size(), 0);
        idle(3);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_frame_rx.md
# cmd_frame_rx

Receive-side command deframer for the flight-command link. It accepts a byte stream from the UART/link layer and hunts for the sync byte. It parses the command id, length and little-endian payload, verifies the 8-bit checksum, and presents each good command on a valid/ready interface to the command-execution FSMs, such as the land-command sender. Malformed, oversize or stalled frames are dropped and counted in saturating error counters.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 4: maximum payload bytes. Fixed at 4 because cmd_param is 32 bits.
- TIMEOUT, 16'd1000: maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- rx_data  in  8: incoming byte.
- rx_valid  in  1: rx_data valid.
- rx_ready  out  1: byte accepted when rx_valid && rx_ready.
- cmd_valid  out  1: decoded command available.
- cmd_ready  in  1: consumer accepts the command.
- cmd_id  out  8: command opcode.
- cmd_len  out  3: payload length, 0..4.
- cmd_param  out  32: payload, little-endian, zero-extended.
- chk_err_cnt  out  8: checksum failures, saturating.
- len_err_cnt  out  8: length-field violations, saturating.
- to_err_cnt  out  8: inter-byte timeouts, saturating.

## Operation
- States: HUNT, GET_CMD, GET_LEN, GET_PAY, GET_CHK, HOLD.
- HUNT: discard accepted bytes until one equals SYNC_BYTE, then go to GET_CMD and clear the running sum and param.
- GET_CMD: latch cmd_id, add the byte to the sum, go to GET_LEN.
- GET_LEN:
  - If the byte is greater than MAX_LEN: increment len_err_cnt and go to HUNT. The byte is not re-examined as a sync.
  - Otherwise latch cmd_len and add the byte to the sum.
  - If the length is 0, go to GET_CHK; else go to GET_PAY.
- GET_PAY: byte k (k = 0..len-1) goes into cmd_param[8k+7:8k] and is added to the sum. After the last byte, go to GET_CHK.
- GET_CHK:
  - If (sum + byte) mod 256 == 0, go to HOLD.
  - Else increment chk_err_cnt and go to HUNT.
- HOLD: cmd_valid = 1 and rx_ready = 0. cmd_id, cmd_len and cmd_param stay stable. When cmd_valid && cmd_ready, go to HUNT.
- rx_ready = 1 in every state except HOLD.
- A SYNC_BYTE value inside a frame is treated as data. There is no resynchronisation mid-frame.
- Sum width: 8 bits, wrapping.
- Timeout:
  - The idle counter clears on every accepted byte and counts only in GET_CMD..GET_CHK.
  - When it reaches TIMEOUT, increment to_err_cnt and go to HUNT.
  - If a byte is accepted in the same cycle the counter reaches TIMEOUT, the byte wins and no timeout is taken.
- Error counters saturate at 8'hFF and clear only on reset.

## Timing
- Reset values: state HUNT, rx_ready 1, cmd_valid 0, cmd_id 0, cmd_len 0, cmd_param 0, all error counters 0.
- One byte is consumed per cycle at full rate. There are no bubbles between frames except the HOLD handshake.
- Latency: cmd_valid rises on the clock edge after the checksum byte handshake.
- When cmd_ready is held high, cmd_valid is high for exactly one cycle. rx_ready returns to 1 in the following cycle.
- Minimum frame cost is 4 bytes plus 1 HOLD cycle.
- Error counters update on the edge that ends the failing byte or timeout cycle.
- Reset asserted mid-frame or in HOLD: outputs immediately take their reset values. The partial or pending command is lost.

## Structure
- Package cmd_pkg holds:
  - the state enum;
  - SYNC_BYTE default and MAX_LEN;
  - opcode constants shared with the sender FSMs, e.g. CMD_LAND = 8'h15, CMD_TAKEOFF = 8'h16, CMD_HOVER = 8'h17.
- Sub-module sat_cnt8: 8-bit saturating counter with an inc input. It is instanced three times, once per error counter.
- Top level holds the FSM, running sum, param shift/insert logic and idle timer.

## Test plan
- Good frame A5 15 02 34 12 A3 at full rate: exactly one cmd_valid pulse with cmd_id=15, cmd_len=2, cmd_param=0x00001234; all counters 0.
- Zero-length frame A5 15 00 EB preceded by garbage 00 FF 3C: one command, cmd_len=0, cmd_param=0.
- Bad checksum A5 15 02 34 12 A4: no cmd_valid, chk_err_cnt=1. A following good frame decodes normally.
- Length field 05 (A5 15 05 ...): len_err_cnt=1, state back to HUNT. A subsequent good frame decodes.
- Frame stalls after A5 15 for TIMEOUT cycles: to_err_cnt=1. A byte arriving exactly on the timeout cycle must not time out.
- Backpressure: hold cmd_ready=0 for 10 cycles after a good frame. rx_ready=0 and outputs are stable throughout. Then 256 bad-checksum frames leave chk_err_cnt=FF (saturated). Asserting reset mid-frame gives all reset values.
